// File: rtl/ripemd160_pkg.sv
// Shared widths and scheduler state encoding for the RIPEMD160 block sequencer.
package ripemd160_pkg;

    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 160;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        OUT
    } sched_state_e;

endpackage

// File: rtl/ripemd160_digest_outreg.sv
// Final-digest holding register with a valid/ready handshake toward the consumer.
module ripemd160_digest_outreg
    import ripemd160_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [DIGEST_W-1:0] i_digest,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [DIGEST_W-1:0] o_digest
);

    logic                r_valid;
    logic [DIGEST_W-1:0] r_digest;

    // The digest value is kept after the handshake; only valid drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_digest <= '0;
        end else if (i_load) begin
            r_valid  <= 1'b1;
            r_digest <= i_digest;
        end else if (r_valid && i_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_digest = r_digest;

endmodule

// File: rtl/ripemd160_block_sched.sv
// Turns a stream of pre-padded 512-bit blocks into RIPEMD160 core init/next commands.
// Optional compression watchdog enabled by defining RIPEMD160_SCHED_WDOG_EN.
//
//   state     | meaning
//   IDLE      | waiting for an input block (s_ready when no digest pending)
//   ISSUE     | block latched, waiting for core_ready to pulse init/next
//   WAIT_BUSY | command sent, waiting for the core to drop core_ready
//   WAIT_DONE | waiting for core_ready & core_digest_valid
//   OUT       | final digest held until m_ready
module ripemd160_block_sched
    import ripemd160_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BLOCK_W-1:0]  s_block,
    input  logic                s_last,
    output logic                core_init,
    output logic                core_next,
    output logic [BLOCK_W-1:0]  core_block,
    input  logic                core_ready,
    input  logic [DIGEST_W-1:0] core_digest,
    input  logic                core_digest_valid,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DIGEST_W-1:0] m_digest,
    output logic [CNT_W-1:0]    blk_cnt,
    output logic                busy,
    output logic                err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    sched_state_e       r_state;
    sched_state_e       w_state_nxt;
    logic               r_first;
    logic               r_last_q;
    logic               r_s_ready;
    logic [BLOCK_W-1:0] r_core_block;
    logic [CNT_W-1:0]   r_blk_cnt;

    logic w_accept;
    logic w_issue;
    logic w_done;
    logic w_load;
    logic w_out_hs;
    logic w_timeout;
    logic w_m_valid;

    assign w_accept = s_valid & r_s_ready;
    assign w_issue  = (r_state == ISSUE) & core_ready;
    assign w_done   = (r_state == WAIT_DONE) & core_ready & core_digest_valid;
    assign w_load   = w_done & r_last_q;
    assign w_out_hs = (r_state == OUT) & w_m_valid & m_ready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:      if (w_accept) w_state_nxt = ISSUE;
            ISSUE:     if (core_ready) w_state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (w_timeout)       w_state_nxt = IDLE;
                else if (!core_ready) w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (w_done)          w_state_nxt = r_last_q ? OUT : IDLE;
                else if (w_timeout)  w_state_nxt = IDLE;
            end
            OUT:       if (w_out_hs) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // s_ready is registered from the next state so it is low in reset and
    // drops in the same edge that accepts a block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_first      <= 1'b1;
            r_last_q     <= 1'b0;
            r_s_ready    <= 1'b0;
            r_core_block <= '0;
            r_blk_cnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= (w_state_nxt == IDLE);
            if (w_accept) begin
                r_core_block <= s_block;
                r_last_q     <= s_last;
            end
            if (w_issue) begin
                r_first <= 1'b0;
                if (r_blk_cnt != '1) r_blk_cnt <= r_blk_cnt + 1'b1;
            end
            if (w_load || w_timeout) r_first <= 1'b1;
            if (w_out_hs || w_timeout) r_blk_cnt <= '0;
        end
    end

`ifdef RIPEMD160_SCHED_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;
    logic            w_waiting;

    assign w_waiting = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
    assign w_timeout = w_waiting && (r_wd_cnt == '0) && !w_done;

    // Loaded at the command pulse; terminal count after TIMEOUT_CYCLES wait cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_issue)
                r_wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
            else if (w_waiting && r_wd_cnt != '0)
                r_wd_cnt <= r_wd_cnt - 1'b1;
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    ripemd160_digest_outreg u_outreg (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_digest (core_digest),
        .i_ready  (m_ready),
        .o_valid  (w_m_valid),
        .o_digest (m_digest)
    );

    assign s_ready    = r_s_ready;
    assign core_init  = w_issue & r_first;
    assign core_next  = w_issue & ~r_first;
    assign core_block = r_core_block;
    assign m_valid    = w_m_valid;
    assign blk_cnt    = r_blk_cnt;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ripemd160_block_sched.sv
// Bench for ripemd160_block_sched: random messages through a behavioural core stub,
// digests checked against a whole-message chaining reference.
module tb_ripemd160_block_sched;

    localparam int CW = 3;
`ifdef RIPEMD160_SCHED_WDOG_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    localparam logic [159:0] H0 = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    logic          clk, reset;
    logic          s_valid, s_ready, s_last;
    logic [511:0]  s_block;
    logic          core_init, core_next, core_ready, core_digest_valid;
    logic [511:0]  core_block;
    logic [159:0]  core_digest, m_digest;
    logic          m_valid, m_ready, busy, err;
    logic [CW-1:0] blk_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulse = 0;
    bit cmd_init_q[$];
    logic [511:0] cmd_blk_q[$];

    ripemd160_block_sched #(.CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_block(s_block), .s_last(s_last),
        .core_init(core_init), .core_next(core_next), .core_block(core_block),
        .core_ready(core_ready), .core_digest(core_digest), .core_digest_valid(core_digest_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_digest(m_digest),
        .blk_cnt(blk_cnt), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Toy compression used by both the core stub and the message reference.
    function automatic logic [159:0] mix(input logic [159:0] h, input logic [511:0] b);
        return {h[152:0], h[159:153]} ^ b[159:0] ^ b[319:160] ^ b[479:320]
               ^ {128'h0, b[511:480]} ^ 160'h5a827999;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Core stub: accepts a command when ready, finishes after 1..5 extra cycles.
    bit stub_stall = 0;
    bit stub_dead = 0;
    bit stub_busy;
    int stub_cnt;
    logic [159:0] stub_h;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_ready <= 1'b1; core_digest_valid <= 1'b0; core_digest <= '0;
            stub_busy <= 1'b0; stub_cnt <= 0; stub_h <= '0;
        end else if (stub_busy) begin
            if (stub_cnt == 0 && !stub_dead) begin
                stub_busy <= 1'b0; core_ready <= 1'b1;
                core_digest <= stub_h; core_digest_valid <= 1'b1;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
            end
        end else if (core_ready && (core_init || core_next)) begin
            stub_h <= mix(core_init ? H0 : stub_h, core_block);
            stub_busy <= 1'b1; stub_cnt <= $urandom_range(1, 5);
            core_ready <= 1'b0; core_digest_valid <= 1'b0;
        end else begin
            core_ready <= !stub_stall;
        end
    end

    // Command monitor
    logic prev_pulse, prev_done, prev_mv;
    always @(negedge clk) begin
        if (reset) begin
            prev_pulse <= 1'b0; prev_done <= 1'b0; prev_mv <= 1'b0;
        end else begin
            if (core_init || core_next) begin
                check("pulse_ready", core_ready, 1);
                check("pulse_excl", core_init & core_next, 0);
                check("pulse_width", prev_pulse, 0);
                cmd_init_q.push_back(core_init);
                cmd_blk_q.push_back(core_block);
                n_pulse++;
            end
            if (m_valid && !prev_mv) check("mv_latency", prev_done, 1);
            prev_pulse <= core_init | core_next;
            prev_done  <= core_ready & core_digest_valid & busy & !m_valid;
            prev_mv    <= m_valid;
        end
    end

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_s_ready"}, s_ready, 0);
        check({pfx, "_core_init"}, core_init, 0);
        check({pfx, "_core_next"}, core_next, 0);
        check({pfx, "_core_block"}, core_block, 0);
        check({pfx, "_m_valid"}, m_valid, 0);
        check({pfx, "_m_digest"}, m_digest, 0);
        check({pfx, "_blk_cnt"}, blk_cnt, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_err"}, err, 0);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_block(input logic [511:0] b, input logic l);
        int n = 0;
        s_valid = 1'b1; s_block = b; s_last = l;
        while (!s_ready && n < 300) begin @(negedge clk); n++; end
        check("send_timeout", n < 300, 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic run_msg(input int n, input int hold, input bit stall);
        logic [511:0] blks[$];
        logic [159:0] h;
        int k;
        bit stable;
        cmd_init_q.delete(); cmd_blk_q.delete();
        h = H0;
        for (int i = 0; i < n; i++) begin
            blks.push_back(rand_block());
            h = mix(h, blks[i]);
        end
        if (hold == 0) m_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (stall && i == 0) stub_stall = 1;
            send_block(blks[i], i == n - 1);
            if (stall && i == 0) begin
                k = n_pulse;
                repeat (6) @(negedge clk);
                check("stall_nopulse", n_pulse, k);
                check("stall_busy", busy, 1);
                check("stall_block", core_block, blks[0]);
                stub_stall = 0;
            end
        end
        k = 0;
        while (!m_valid && k < 300) begin @(negedge clk); k++; end
        check("mv_timeout", k < 300, 1);
        check("digest", m_digest, h);
        check("blk_cnt", blk_cnt, (n > 7) ? 7 : n);
        check("s_ready_pending", s_ready, 0);
        check("cmd_count", cmd_init_q.size(), n);
        for (int i = 0; i < n && i < cmd_init_q.size(); i++) begin
            check("cmd_kind", cmd_init_q[i], i == 0);
            check("cmd_block", cmd_blk_q[i], blks[i]);
        end
        if (hold > 0) begin
            stable = 1;
            repeat (hold) begin
                @(negedge clk);
                if (m_digest !== h || s_ready !== 1'b0 || m_valid !== 1'b1) stable = 0;
            end
            check("bp_stable", stable, 1);
            m_ready = 1'b1;
        end
        @(negedge clk);
        check("out_mv_drop", m_valid, 0);
        check("out_s_ready", s_ready, 1);
        check("out_blk_clr", blk_cnt, 0);
        m_ready = 1'b0;
    endtask

    initial begin
        int k;
        logic [511:0] b1, b2;
        reset = 1'b1; s_valid = 1'b0; s_block = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_s_ready", s_ready, 1);

        run_msg(1, 0, 0);
        run_msg(3, 20, 0);
        run_msg(2, 0, 0);
        run_msg(9, 3, 0);
        run_msg(2, 2, 1);

        // Reset while the second block of a message is compressing
        b1 = rand_block(); b2 = rand_block();
        send_block(b1, 1'b0);
        send_block(b2, 1'b0);
        k = 0;
        while (core_ready && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_blk_cnt", blk_cnt, 2);
        #2 reset = 1'b1;
        #1 check_reset_vals("async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_msg(2, 1, 0);

`ifdef RIPEMD160_SCHED_WDOG_EN
        stub_dead = 1;
        send_block(rand_block(), 1'b1);
        k = 0;
        while (!(core_init || core_next) && k < 50) begin @(negedge clk); k++; end
        check("wd_pulse_seen", k < 50, 1);
        k = 0;
        while (!err && k < 50) begin @(negedge clk); k++; end
        check("wd_cycles", (k >= TO) && (k <= TO + 1), 1);
        check("wd_idle", busy, 0);
        check("wd_no_mv", m_valid, 0);
        check("wd_blk_clr", blk_cnt, 0);
        repeat (5) @(negedge clk);
        check("wd_sticky", err, 1);
        check("wd_still_no_mv", m_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        stub_dead = 0;
        reset = 1'b0;
        @(negedge clk);
        check("wd_err_clr", err, 0);
        run_msg(1, 1, 0);
`endif
        check("final_err", err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/ripemd160_block_sched.md
Name: ripemd160_block_sched

Overview:
Sequencer in front of the RIPEMD160 core that turns a stream of pre-padded 512-bit message blocks into core commands.
- Issues init for the first block of a message and next for each following block.
- Waits for each compression to finish.
- Holds the final digest in an output register with a valid/ready handshake.
- Sits between the Hash160 message front end (padder/SHA-256 stage) and the RIPEMD160 core; it is the only driver of the core's init/next/block pins.

Parameters:
CNT_W, 16, width of the per-message block counter (blk_cnt), saturating.
TIMEOUT_CYCLES, 255, watchdog limit in cycles per compression (used only with the optional feature).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous active-high reset.
s_valid  input  1  input block valid.
s_ready  output  1  scheduler accepts a block this cycle.
s_block  input  512  pre-padded message block, same bit order as the core's block port.
s_last  input  1  block is the final block of its message.
core_init  output  1  one-cycle pulse: start new message with core_block.
core_next  output  1  one-cycle pulse: continue chain with core_block.
core_block  output  512  registered block presented to the core.
core_ready  input  1  core idle, can take a command.
core_digest  input  160  core chaining value/digest.
core_digest_valid  input  1  core digest valid.
m_valid  output  1  final digest available.
m_ready  input  1  downstream consumes digest.
m_digest  output  160  final digest register.
blk_cnt  output  CNT_W  blocks issued for the current message.
busy  output  1  state != IDLE.
err  output  1  sticky watchdog error (optional feature; otherwise tied 0).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; s_ready=0, core_init=0, core_next=0, core_block=0, m_valid=0, m_digest=0, blk_cnt=0, busy=0, err=0. Internal first=1.
- States and transitions:
  - IDLE: s_ready=1 when m_valid=0. On s_valid&s_ready:
    - latch s_block into core_block and s_last into last_q;
    - go to ISSUE.
  - ISSUE: wait for core_ready=1. Then pulse exactly one of core_init (first=1) or core_next (first=0) for one cycle. Clear first, increment blk_cnt, go to WAIT_BUSY.
  - WAIT_BUSY: wait for core_ready=0 (core accepted the command), then go to WAIT_DONE.
  - WAIT_DONE: wait for core_ready=1 and core_digest_valid=1.
    - If last_q=1: capture core_digest into m_digest, set m_valid=1, set first=1, go to OUT.
    - Otherwise: return to IDLE to accept the next block.
  - OUT: hold m_valid and m_digest stable until m_valid&m_ready. Then clear m_valid, clear blk_cnt, go to IDLE.
- s_ready is 0 in every state except IDLE with m_valid=0. Input blocks are never accepted while a digest is pending.
- Latency: a block is accepted at cycle T; the command pulse is at T+1 at the earliest; m_valid is asserted one cycle after core_digest_valid&core_ready is seen for the last block.
- core_block stays stable from acceptance until the state returns to IDLE.
- Boundary conditions:
  - Single-block message: init only, no next.
  - blk_cnt saturates at all-ones.
  - m_ready held high: OUT lasts exactly one cycle.
  - core_ready already 0 in ISSUE: stall, no pulse.
  - Reset mid-message: abandons the chain; the next accepted block uses init.

Optional Feature:
Macro RIPEMD160_SCHED_WDOG_EN.
- With the macro: a cycle counter runs in WAIT_BUSY and WAIT_DONE. If it reaches TIMEOUT_CYCLES:
  - set err (sticky until reset);
  - set first=1 and clear blk_cnt;
  - drop the message, with no m_valid;
  - return to IDLE.
- Without the macro: no counter; err is tied 0; the block waits indefinitely.

Decomposition:
- Shared package ripemd160_pkg: BLOCK_W=512, DIGEST_W=160, state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUT).
- One sub-module is natural: ripemd160_digest_outreg, the 160-bit valid/ready output holding register used for m_valid/m_digest.

Test Plan:
- Single block 512'h…80676e61592072657473614d with s_last=1 and the core attached: exactly one core_init pulse, zero core_next; m_digest=160'hfedcd200dc0f8b4c51ad7ae734282ff2008bbb12; blk_cnt=1 while m_valid=1.
- Three-block message: init, next, next in order, one cycle each; m_valid only after the third completion; blk_cnt=3.
- Backpressure: m_ready=0 for 20 cycles → m_digest stable, s_ready=0 throughout; m_ready=1 → m_valid drops the next cycle and s_ready rises.
- Two messages back to back: the second message's first block produces core_init, not core_next.
- Reset asserted during WAIT_DONE of block 2 → all outputs at reset values immediately (async); the following message starts with init.
- With RIPEMD160_SCHED_WDOG_EN and TIMEOUT_CYCLES=8, a core-model stub never returning ready → err=1 after 8 cycles, state IDLE, m_valid stays 0.
